proc_io_bridge: RTL and testbench

Peripheral-side counterpart to the processor's external I/O interface. It accepts outbound words that the processor emits with snd/interface_data and serializes them as bytes onto the board link. It buffers inbound 32-bit link words and a synchronized key press, then presents them to the processor one at a time as interrupt_key/interrupt_eth pulses with interrupt_source_data. It sits between the processor top level and the link/IO pins.

---
 rtl/proc_io_bridge_pkg.sv | 22 ++
 rtl/proc_io_bridge_if.sv | 36 +++
 rtl/proc_io_bridge_sync_fifo.sv | 47 ++++
 rtl/proc_io_bridge.sv | 155 +++++++++++++++
 tb/tb_proc_io_bridge.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_io_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  proc_io_pkg : shared state encodings and constants for proc_io_bridge
//  Rev 1.0
// ============================================================================
package proc_io_pkg;

    typedef logic [0:0] tx_state_t;
    localparam tx_state_t TX_IDLE = 1'b0;
    localparam tx_state_t TX_SEND = 1'b1;

    typedef logic [1:0] irq_state_t;
    localparam irq_state_t IRQ_IDLE  = 2'd0;
    localparam irq_state_t IRQ_PULSE = 2'd1;
    localparam irq_state_t IRQ_WAIT  = 2'd2;

    localparam int unsigned WORD_W           = 32;
    localparam int unsigned BYTE_W           = 8;
    localparam logic [31:0] KEY_DATA_DEFAULT = 32'hFFFF_0001;

endpackage
`default_nettype wire

// File: rtl/proc_io_bridge_if.sv
`default_nettype none
// ============================================================================
//  proc_io_bridge_if : processor/link signal bundle seen by the bridge
//  Rev 1.0
// ============================================================================
interface proc_io_bridge_if;
    import proc_io_pkg::*;

    logic                snd;
    logic [WORD_W-1:0]   interface_data;
    logic                tx_valid;
    logic [BYTE_W-1:0]   tx_data;
    logic                tx_ready;
    logic                tx_drop;
    logic                rx_valid;
    logic [WORD_W-1:0]   rx_data;
    logic                rx_ready;
    logic                key_in;
    logic                intr_done;
    logic                interrupt_key;
    logic                interrupt_eth;
    logic [WORD_W-1:0]   interrupt_source_data;

    modport master (
        output snd, interface_data, tx_ready, rx_valid, rx_data, key_in, intr_done,
        input  tx_valid, tx_data, tx_drop, rx_ready,
               interrupt_key, interrupt_eth, interrupt_source_data
    );

    modport slave (
        input  snd, interface_data, tx_ready, rx_valid, rx_data, key_in, intr_done,
        output tx_valid, tx_data, tx_drop, rx_ready,
               interrupt_key, interrupt_eth, interrupt_source_data
    );
endinterface
`default_nettype wire

// File: rtl/proc_io_bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
//  sync_fifo : single-clock FIFO, show-ahead head, overflow/underflow gated
//  Rev 1.0
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [WIDTH-1:0]      head_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule
`default_nettype wire

// File: rtl/proc_io_bridge.sv
`default_nettype none
// ============================================================================
//  proc_io_bridge : serializes processor words onto the byte link and turns
//  inbound link words / key presses into single-cycle interrupts.  Rev 1.0
// ============================================================================
module proc_io_bridge
    import proc_io_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4,
    parameter int unsigned RX_DEPTH = 4,
    parameter logic [31:0] KEY_DATA = KEY_DATA_DEFAULT
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    proc_io_bridge_if.slave   bus
);
    logic              tx_full, tx_empty, tx_pop;
    logic [WORD_W-1:0] tx_head;
    logic              rx_full, rx_empty, rx_pop, rx_push;
    logic [WORD_W-1:0] rx_head;

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(bus.snd), .data_i(bus.interface_data),
        .pop_i(tx_pop), .full_o(tx_full), .empty_o(tx_empty), .head_o(tx_head)
    );

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push_i(rx_push), .data_i(bus.rx_data),
        .pop_i(rx_pop), .full_o(rx_full), .empty_o(rx_empty), .head_o(rx_head)
    );

    // rx_ready is held low until the first clock after reset so every output reads 0 in reset.
    logic rx_en_q;
    assign bus.rx_ready = ~rx_full & rx_en_q;
    assign rx_push      = bus.rx_valid & bus.rx_ready;

    tx_state_t         tx_state_q, tx_state_d;
    logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
    logic [1:0]        tx_cnt_q, tx_cnt_d;
    logic              tx_valid_q, tx_valid_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              tx_drop_q, tx_drop_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_drop_d  = tx_drop_q | (bus.snd & tx_full);
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_data_d  = tx_head[31:24];
                tx_shift_d = {tx_head[23:0], 8'h00};
                tx_cnt_d   = 2'd0;
                tx_valid_d = 1'b1;
                tx_state_d = TX_SEND;
            end
            TX_SEND: if (bus.tx_ready) begin
                if (tx_cnt_q == 2'd3) begin
                    tx_valid_d = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_data_d  = tx_shift_q[31:24];
                    tx_shift_d = {tx_shift_q[23:0], 8'h00};
                    tx_cnt_d   = tx_cnt_q + 2'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    logic              key_s1_q, key_s2_q, key_s3_q, key_rise;
    logic              key_pending_q, key_pending_d;
    irq_state_t        irq_state_q, irq_state_d;
    logic              irq_key_q, irq_key_d, irq_eth_q, irq_eth_d;
    logic [WORD_W-1:0] irq_data_q, irq_data_d;

    assign key_rise = key_s2_q & ~key_s3_q;

    always_comb begin
        irq_state_d   = irq_state_q;
        key_pending_d = key_pending_q;
        irq_data_d    = irq_data_q;
        irq_key_d     = 1'b0;
        irq_eth_d     = 1'b0;
        rx_pop        = 1'b0;
        case (irq_state_q)
            IRQ_IDLE: begin
                if (key_pending_q) begin
                    irq_data_d    = KEY_DATA;
                    key_pending_d = 1'b0;
                    irq_key_d     = 1'b1;
                    irq_state_d   = IRQ_PULSE;
                end else if (!rx_empty) begin
                    irq_data_d  = rx_head;
                    rx_pop      = 1'b1;
                    irq_eth_d   = 1'b1;
                    irq_state_d = IRQ_PULSE;
                end
            end
            IRQ_PULSE: irq_state_d = IRQ_WAIT;
            IRQ_WAIT:  if (bus.intr_done) irq_state_d = IRQ_IDLE;
            default:   irq_state_d = IRQ_IDLE;
        endcase
        // A fresh edge outranks the clear so no press is lost.
        if (key_rise) key_pending_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_en_q       <= 1'b0;
            tx_state_q    <= TX_IDLE;
            tx_shift_q    <= '0;
            tx_cnt_q      <= '0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            tx_drop_q     <= 1'b0;
            key_s1_q      <= 1'b0;
            key_s2_q      <= 1'b0;
            key_s3_q      <= 1'b0;
            key_pending_q <= 1'b0;
            irq_state_q   <= IRQ_IDLE;
            irq_key_q     <= 1'b0;
            irq_eth_q     <= 1'b0;
            irq_data_q    <= '0;
        end else begin
            rx_en_q       <= 1'b1;
            tx_state_q    <= tx_state_d;
            tx_shift_q    <= tx_shift_d;
            tx_cnt_q      <= tx_cnt_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            tx_drop_q     <= tx_drop_d;
            key_s1_q      <= bus.key_in;
            key_s2_q      <= key_s1_q;
            key_s3_q      <= key_s2_q;
            key_pending_q <= key_pending_d;
            irq_state_q   <= irq_state_d;
            irq_key_q     <= irq_key_d;
            irq_eth_q     <= irq_eth_d;
            irq_data_q    <= irq_data_d;
        end
    end

    assign bus.tx_valid              = tx_valid_q;
    assign bus.tx_data               = tx_data_q;
    assign bus.tx_drop               = tx_drop_q;
    assign bus.interrupt_key         = irq_key_q;
    assign bus.interrupt_eth         = irq_eth_q;
    assign bus.interrupt_source_data = irq_data_q;
endmodule
`default_nettype wire

// File: tb/tb_proc_io_bridge.sv
`default_nettype none
// ============================================================================
//  tb_proc_io_bridge : directed self-checking bench for proc_io_bridge
//  Rev 1.0
// ============================================================================
module tb_proc_io_bridge;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    proc_io_bridge_if bus();

    proc_io_bridge #(.TX_DEPTH(4), .RX_DEPTH(4), .KEY_DATA(32'hFFFF_0001)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0]  t1_bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [31:0] t3_words [6] = '{32'h1112_1314, 32'h2122_2324, 32'h3132_3334,
                                  32'h4142_4344, 32'h5152_5354, 32'h6162_6364};
    logic [7:0]  t7_bytes [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};

    initial begin
        int          nb;
        int          acc;
        logic [31:0] w;

        rst_n              = 1'b0;
        bus.snd            = 1'b0;
        bus.interface_data = '0;
        bus.tx_ready       = 1'b0;
        bus.rx_valid       = 1'b0;
        bus.rx_data        = '0;
        bus.key_in         = 1'b0;
        bus.intr_done      = 1'b0;
        step(2);

        check_eq("rst tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check_eq("rst tx_data", {24'd0, bus.tx_data}, 32'd0);
        check_eq("rst tx_drop", {31'd0, bus.tx_drop}, 32'd0);
        check_eq("rst rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        check_eq("rst int_key", {31'd0, bus.interrupt_key}, 32'd0);
        check_eq("rst int_eth", {31'd0, bus.interrupt_eth}, 32'd0);
        check_eq("rst src_data", bus.interrupt_source_data, 32'd0);

        rst_n = 1'b1;
        step();
        check_eq("post-rst rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Single word, link always ready
        bus.tx_ready       = 1'b1;
        bus.interface_data = 32'hA1B2_C3D4;
        bus.snd            = 1'b1;
        step();
        bus.snd = 1'b0;
        check_eq("t1 valid N+1", {31'd0, bus.tx_valid}, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1 valid b%0d", i), {31'd0, bus.tx_valid}, 32'd1);
            check_eq($sformatf("t1 data b%0d", i), {24'd0, bus.tx_data}, {24'd0, t1_bytes[i]});
            step();
        end
        check_eq("t1 valid N+6", {31'd0, bus.tx_valid}, 32'd0);

        // Backpressure while B2 is presented
        bus.snd = 1'b1;
        step();
        bus.snd = 1'b0;
        step();
        check_eq("t2 A1", {24'd0, bus.tx_data}, 32'h0000_00A1);
        step();
        check_eq("t2 B2", {24'd0, bus.tx_data}, 32'h0000_00B2);
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("t2 hold valid %0d", i), {31'd0, bus.tx_valid}, 32'd1);
            check_eq($sformatf("t2 hold B2 %0d", i), {24'd0, bus.tx_data}, 32'h0000_00B2);
        end
        bus.tx_ready = 1'b1;
        step();
        check_eq("t2 C3", {24'd0, bus.tx_data}, 32'h0000_00C3);
        step();
        check_eq("t2 D4", {24'd0, bus.tx_data}, 32'h0000_00D4);
        step();
        check_eq("t2 idle", {31'd0, bus.tx_valid}, 32'd0);
        check_eq("t2 no drop", {31'd0, bus.tx_drop}, 32'd0);

        // Overflow: six words with link stalled; sixth is dropped
        bus.tx_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.interface_data = t3_words[k];
            bus.snd            = 1'b1;
            step();
        end
        bus.snd = 1'b0;
        check_eq("t3 tx_drop", {31'd0, bus.tx_drop}, 32'd1);
        bus.tx_ready = 1'b1;
        nb = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.tx_valid) begin
                if (nb < 20) begin
                    w = t3_words[nb / 4];
                    check_eq($sformatf("t3 byte%0d", nb), {24'd0, bus.tx_data},
                             {24'd0, w[31 - 8 * (nb % 4) -: 8]});
                end
                nb++;
            end
            step();
        end
        check_eq("t3 byte count", nb, 32'd20);

        // Inbound word interrupt, second word waits for intr_done
        bus.rx_data  = 32'h0000_0042;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_data = 32'h0000_0055;
        check_eq("t4 eth early", {31'd0, bus.interrupt_eth}, 32'd0);
        step();
        bus.rx_valid = 1'b0;
        check_eq("t4 eth pulse", {31'd0, bus.interrupt_eth}, 32'd1);
        check_eq("t4 key quiet", {31'd0, bus.interrupt_key}, 32'd0);
        check_eq("t4 src 42", bus.interrupt_source_data, 32'h0000_0042);
        step();
        check_eq("t4 eth 1cyc", {31'd0, bus.interrupt_eth}, 32'd0);
        step(3);
        check_eq("t4 eth wait", {31'd0, bus.interrupt_eth}, 32'd0);
        check_eq("t4 src held", bus.interrupt_source_data, 32'h0000_0042);
        bus.intr_done = 1'b1;
        step();
        bus.intr_done = 1'b0;
        check_eq("t4 eth idle", {31'd0, bus.interrupt_eth}, 32'd0);
        step();
        check_eq("t4 eth 2nd", {31'd0, bus.interrupt_eth}, 32'd1);
        check_eq("t4 src 55", bus.interrupt_source_data, 32'h0000_0055);
        step();
        check_eq("t4 eth 2nd off", {31'd0, bus.interrupt_eth}, 32'd0);
        bus.intr_done = 1'b1;
        step();
        bus.intr_done = 1'b0;

        // Key edge and rx word land together: key wins
        bus.key_in = 1'b1;
        step(2);
        bus.rx_data  = 32'h0000_0077;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        check_eq("t5 key early", {31'd0, bus.interrupt_key}, 32'd0);
        step();
        check_eq("t5 key pulse", {31'd0, bus.interrupt_key}, 32'd1);
        check_eq("t5 eth quiet", {31'd0, bus.interrupt_eth}, 32'd0);
        check_eq("t5 key data", bus.interrupt_source_data, 32'hFFFF_0001);
        step();
        check_eq("t5 key off", {31'd0, bus.interrupt_key}, 32'd0);
        check_eq("t5 key data held", bus.interrupt_source_data, 32'hFFFF_0001);
        bus.intr_done = 1'b1;
        step();
        bus.intr_done = 1'b0;
        check_eq("t5 eth not yet", {31'd0, bus.interrupt_eth}, 32'd0);
        step();
        check_eq("t5 eth pulse", {31'd0, bus.interrupt_eth}, 32'd1);
        check_eq("t5 eth data", bus.interrupt_source_data, 32'h0000_0077);
        step();
        bus.intr_done = 1'b1;
        step();
        bus.intr_done = 1'b0;
        bus.key_in    = 1'b0;

        // Inbound backpressure with intr_done withheld
        acc          = 0;
        bus.rx_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bus.rx_data = 32'h0000_0A00 + acc;
            if (bus.rx_ready) acc++;
            step();
        end
        bus.rx_valid = 1'b0;
        check_eq("t6 accepted", acc, 32'd5);
        check_eq("t6 rx_ready low", {31'd0, bus.rx_ready}, 32'd0);
        check_eq("t6 src first", bus.interrupt_source_data, 32'h0000_0A00);

        // Async reset in the middle of a byte transfer
        bus.tx_ready       = 1'b0;
        bus.interface_data = 32'hDEAD_BEEF;
        bus.snd            = 1'b1;
        step();
        bus.snd = 1'b0;
        step();
        check_eq("t7 mid valid", {31'd0, bus.tx_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("t7 rst tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check_eq("t7 rst tx_drop", {31'd0, bus.tx_drop}, 32'd0);
        check_eq("t7 rst int_key", {31'd0, bus.interrupt_key}, 32'd0);
        check_eq("t7 rst int_eth", {31'd0, bus.interrupt_eth}, 32'd0);
        check_eq("t7 rst src", bus.interrupt_source_data, 32'd0);
        check_eq("t7 rst rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        step(2);
        rst_n = 1'b1;
        step();
        check_eq("t7 rel rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check_eq("t7 rel no resume", {31'd0, bus.tx_valid}, 32'd0);
        bus.tx_ready       = 1'b1;
        bus.interface_data = 32'hCAFE_F00D;
        bus.snd            = 1'b1;
        step();
        bus.snd = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t7 data b%0d", i), {24'd0, bus.tx_data}, {24'd0, t7_bytes[i]});
            step();
        end
        check_eq("t7 idle", {31'd0, bus.tx_valid}, 32'd0);
        bus.rx_data  = 32'h0000_0099;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        step();
        check_eq("t7 eth pulse", {31'd0, bus.interrupt_eth}, 32'd1);
        check_eq("t7 eth data", bus.interrupt_source_data, 32'h0000_0099);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
